// File: rtl/raisin64_pkg.sv
// -----------------------------------------------------------------------------
// raisin64_pkg
// Shared constants for the Raisin64 front end: instruction length codes,
// halfword geometry of the fetch path, and helpers that decode the head
// halfword's length prefix.
//
// Contents:
//   len_e        - length code carried with every aligned instruction
//   HW_BITS      - bits per halfword
//   HW_PER_WORD  - halfwords per 64-bit fetch word
//   HW_BUF       - halfword capacity of the alignment buffer
//   HC_W         - width of the buffer's halfword count
//   hwLen()      - instruction length in halfwords from the top two bits
//   lenCodeOf()  - length code from the top two bits
// -----------------------------------------------------------------------------
package raisin64_pkg;

  typedef enum logic [1:0] {
    LEN16 = 2'd0,
    LEN32 = 2'd1,
    LEN64 = 2'd2
  } len_e;

  localparam int HW_BITS     = 16;
  localparam int HW_PER_WORD = 4;
  localparam int HW_BUF      = 8;
  localparam int HC_W        = 4;

  // Top bit 0 marks a 16-bit instruction; prefix 10 is 32-bit, 11 is 64-bit.
  function automatic logic [2:0] hwLen(input logic [1:0] top);
    logic [2:0] len;
    if (!top[1]) begin
      len = 3'd1;
    end else if (!top[0]) begin
      len = 3'd2;
    end else begin
      len = 3'd4;
    end
    return len;
  endfunction

  function automatic len_e lenCodeOf(input logic [1:0] top);
    len_e code;
    if (!top[1]) begin
      code = LEN16;
    end else if (!top[0]) begin
      code = LEN32;
    end else begin
      code = LEN64;
    end
    return code;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Synchronous FIFO holding aligned instructions. The head entry is driven
// straight from storage, so an entry is visible the cycle after it is pushed,
// and it stays put until popped. An empty FIFO drives zeros on rdata.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (clears pointers)
//   clear           - synchronous empty, wins over push/pop
//   push, wdata     - write an entry (accepted when not full or popping)
//   pop             - remove the head entry (ignored when empty)
//   rdata           - head entry, zero when empty
//   full, empty     - occupancy flags
// -----------------------------------------------------------------------------
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 130
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // A push into a full FIFO is allowed only when the head leaves the same cycle.
  always_comb begin
    empty  = (wr_q == rd_q);
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    doPop  = pop & ~empty;
    doPush = push & (~full | doPop);
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (clear) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (doPush) wr_d = wr_q + (AW+1)'(1);
      if (doPop)  rd_d = rd_q + (AW+1)'(1);
    end
    rdata = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only observable between the pointers.
  always_ff @(posedge clk) begin
    if (doPush && !clear) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/inst_align.sv
// -----------------------------------------------------------------------------
// inst_align
// Splits a stream of 8-byte-aligned fetch words into variable-length
// (16/32/64-bit) instructions. Halfwords collect in a 128-bit shift buffer,
// head at the top; one instruction per cycle moves into an output queue
// together with its length code and byte address.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush, flush_pc       - drop everything and restart at flush_pc
//   in_valid, in_data     - fetch word (halfword 0 in [63:48])
//   in_ready              - fetch word accepted when in_valid & in_ready
//   out_valid             - queue head valid
//   out_inst              - instruction, left-aligned, low bits zero
//   out_len               - 0 = 16-bit, 1 = 32-bit, 2 = 64-bit
//   out_pc                - byte address of out_inst
//   out_ready             - consumer pops the head
// -----------------------------------------------------------------------------
module inst_align
  import raisin64_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            in_valid,
  input  logic [63:0]     in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [63:0]     out_inst,
  output logic [1:0]      out_len,
  output logic [PC_W-1:0] out_pc,
  input  logic            out_ready
);

  localparam int BUF_W   = HW_BUF * HW_BITS;
  localparam int ENTRY_W = 64 + 2 + PC_W;

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic [1:0]       drop_q, drop_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  logic [2:0]       headLenHw;
  len_e             headLenCode;
  logic [63:0]      instWord;
  logic [BUF_W-1:0] shiftedBuf;
  logic [BUF_W-1:0] remBuf;
  logic [HC_W-1:0]  remHc;
  logic [63:0]      newWord;
  logic [HC_W-1:0]  newCount;
  logic [BUF_W-1:0] appendBuf;
  logic             accept;
  logic             extract;
  logic             pop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [ENTRY_W-1:0] fifoWdata;
  logic [ENTRY_W-1:0] fifoRdata;

  // A word can only be taken when the remainder after any extraction still
  // leaves room for all four halfwords, which HC <= 4 guarantees.
  assign in_ready  = (hc_q <= HC_W'(HW_PER_WORD)) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = ~fifoEmpty;
  assign pop       = out_valid & out_ready;

  // Decode the head instruction and build the post-extraction remainder.
  always_comb begin
    headLenHw   = hwLen(buf_q[BUF_W-1 -: 2]);
    headLenCode = lenCodeOf(buf_q[BUF_W-1 -: 2]);
    case (headLenHw)
      3'd1: begin
        instWord   = {buf_q[BUF_W-1 -: 16], 48'b0};
        shiftedBuf = buf_q << 16;
      end
      3'd2: begin
        instWord   = {buf_q[BUF_W-1 -: 32], 32'b0};
        shiftedBuf = buf_q << 32;
      end
      default: begin
        instWord   = buf_q[BUF_W-1 -: 64];
        shiftedBuf = buf_q << 64;
      end
    endcase
    extract = (HC_W'(headLenHw) <= hc_q) && (!fifoFull || pop) && !flush;
    remBuf  = extract ? shiftedBuf : buf_q;
    remHc   = extract ? (hc_q - HC_W'(headLenHw)) : hc_q;
  end

  // The first word after a flush may start mid-word; leading halfwords are
  // shifted off so the restart halfword lands at the top of newWord.
  always_comb begin
    case (drop_q)
      2'd0:    newWord = in_data;
      2'd1:    newWord = {in_data[47:0], 16'b0};
      2'd2:    newWord = {in_data[31:0], 32'b0};
      default: newWord = {in_data[15:0], 48'b0};
    endcase
    newCount  = HC_W'(HW_PER_WORD) - HC_W'(drop_q);
    appendBuf = {newWord, 64'b0} >> {remHc, 4'b0000};
  end

  // Next-state: flush beats everything; otherwise extraction and appending
  // combine so the incoming word sits directly after the remainder.
  always_comb begin
    if (flush) begin
      buf_d  = '0;
      hc_d   = '0;
      drop_d = flush_pc[2:1];
      pc_d   = flush_pc;
    end else begin
      buf_d  = remBuf | (accept ? appendBuf : '0);
      hc_d   = remHc + (accept ? newCount : '0);
      drop_d = accept ? 2'd0 : drop_q;
      pc_d   = extract ? (pc_q + PC_W'({headLenHw, 1'b0})) : pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      hc_q   <= '0;
      drop_q <= '0;
      pc_q   <= '0;
    end else begin
      buf_q  <= buf_d;
      hc_q   <= hc_d;
      drop_q <= drop_d;
      pc_q   <= pc_d;
    end
  end

  assign fifoWdata = {instWord, headLenCode, pc_q};

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (extract),
    .wdata (fifoWdata),
    .pop   (pop),
    .rdata (fifoRdata),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign {out_inst, out_len, out_pc} = fifoRdata;

endmodule

// File: tb/tb_inst_align.sv
// -----------------------------------------------------------------------------
// tb_inst_align
// Scoreboard bench for inst_align. Directed scenarios push hand-computed
// entries; the remaining scenarios use a halfword-queue model of the
// instruction stream. A negedge monitor compares every popped head.
// -----------------------------------------------------------------------------
module tb_inst_align;

  typedef struct {
    logic [63:0] inst;
    logic [1:0]  len;
    logic [63:0] pc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [63:0] flush_pc;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_inst;
  logic [1:0]  out_len;
  logic [63:0] out_pc;
  logic        out_ready;

  exp_t        expQ[$];
  logic [15:0] hwQ[$];
  logic [63:0] modelPc;
  int          modelDrop;
  int          modelCount;
  bit          useModel;
  int          checkCount;
  int          passCount;

  inst_align #(.DEPTH(4), .PC_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_len   (out_len),
    .out_pc    (out_pc),
    .out_ready (out_ready)
  );

  // Free-running clock, posedges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accepted halfwords join a queue, complete instructions
  // leave it in program order with their byte address.
  function automatic void modelIngest(input logic [63:0] w);
    exp_t e;
    int   l;
    for (int i = modelDrop; i < 4; i++) hwQ.push_back(w[63-16*i -: 16]);
    modelDrop = 0;
    while (hwQ.size() > 0) begin
      l = hwQ[0][15] ? (hwQ[0][14] ? 4 : 2) : 1;
      if (hwQ.size() < l) break;
      e.inst = '0;
      for (int k = 0; k < l; k++) e.inst[63-16*k -: 16] = hwQ[k];
      e.len  = (l == 1) ? 2'd0 : ((l == 2) ? 2'd1 : 2'd2);
      e.pc   = modelPc;
      modelPc = modelPc + 64'(2 * l);
      for (int k = 0; k < l; k++) void'(hwQ.pop_front());
      expQ.push_back(e);
      modelCount++;
    end
  endfunction

  function automatic void pushExp(input logic [63:0] inst, input logic [1:0] len, input logic [63:0] pc);
    exp_t e;
    e.inst = inst;
    e.len  = len;
    e.pc   = pc;
    expQ.push_back(e);
  endfunction

  // Monitor: compare each popped head against the scoreboard, then feed
  // accepted words to the model.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checkCount++;
        if (expQ.size() == 0) begin
          $display("[TB] FAIL unexpected_output: got inst=%h len=%0d pc=%h, required no output", out_inst, out_len, out_pc);
        end else begin
          e = expQ.pop_front();
          if (out_inst === e.inst && out_len === e.len && out_pc === e.pc) begin
            passCount++;
          end else begin
            $display("[TB] FAIL output_entry: got inst=%h len=%0d pc=%h, required inst=%h len=%0d pc=%h",
                     out_inst, out_len, out_pc, e.inst, e.len, e.pc);
          end
        end
      end
      if (in_valid && in_ready && useModel) modelIngest(in_data);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until it is taken, bounded.
  task automatic applyStimulus(input logic [63:0] word);
    bit done;
    int tries;
    done  = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_data  = word;
    while (!done && tries < 50) begin
      @(negedge clk);
      done = in_ready;
      step();
      tries++;
    end
    in_valid = 1'b0;
    checkOutput("word_accepted", 64'(done), 64'd1);
  endtask

  task automatic doFlush(input logic [63:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    in_valid = 1'b0;
    step();
    flush = 1'b0;
    expQ.delete();
    hwQ.delete();
    modelPc   = pc;
    modelDrop = int'(pc[2:1]);
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while (expQ.size() > 0 && n < maxCycles) begin
      step();
      n++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    checkCount = 0;
    passCount  = 0;
    useModel   = 1'b0;
    modelPc    = '0;
    modelDrop  = 0;
    modelCount = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    // Reset state
    #3;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_inst", out_inst, 64'd0);
    checkOutput("reset_out_len", 64'(out_len), 64'd0);
    checkOutput("reset_out_pc", out_pc, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    step();

    // Mixed 16/32-bit word at 0x100, then zero halfwords
    doFlush(64'h100);
    useModel  = 1'b0;
    out_ready = 1'b1;
    pushExp(64'h1111_0000_0000_0000, 2'd0, 64'h100);
    pushExp(64'h2222_0000_0000_0000, 2'd0, 64'h102);
    pushExp(64'h8333_4444_0000_0000, 2'd1, 64'h104);
    pushExp(64'h0, 2'd0, 64'h108);
    pushExp(64'h0, 2'd0, 64'h10A);
    pushExp(64'h0, 2'd0, 64'h10C);
    pushExp(64'h0, 2'd0, 64'h10E);
    applyStimulus(64'h1111_2222_8333_4444);
    checkOutput("first_latency_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(64'h0);
    waitDrain("mixed_drain", 40);

    // 64-bit instruction straddling two words after a mid-word flush
    doFlush(64'h206);
    pushExp(64'hC000_0000_0001_0002, 2'd2, 64'h206);
    pushExp(64'h0003_0000_0000_0000, 2'd0, 64'h20E);
    applyStimulus(64'hAAAA_BBBB_CCCC_C000);
    repeat (3) step();
    checkOutput("straddle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("straddle_out_valid", 64'(out_valid), 64'd0);
    checkOutput("straddle_hc", 64'(dut.hc_q), 64'd1);
    applyStimulus(64'h0000_0001_0002_0003);
    waitDrain("straddle_drain", 40);

    // Backpressure: queue fills, buffer fills, then a single pop
    doFlush(64'h0);
    useModel  = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h0001_0002_0003_0004;
    repeat (10) step();
    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_hc", 64'(dut.hc_q), 64'd8);
    checkOutput("bp_full", 64'(dut.u_fifo.full), 64'd1);
    checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("bp_pop_refill_full", 64'(dut.u_fifo.full), 64'd1);
    checkOutput("bp_pop_hc", 64'(dut.hc_q), 64'd7);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain("bp_drain", 40);

    // Flush while entries are queued and HC = 6
    doFlush(64'h0);
    out_ready = 1'b0;
    applyStimulus(64'h0001_0002_C000_0000);
    repeat (4) step();
    checkOutput("pre_flush_hc2", 64'(dut.hc_q), 64'd2);
    applyStimulus(64'h1111_2222_3333_4444);
    checkOutput("pre_flush_hc6", 64'(dut.hc_q), 64'd6);
    checkOutput("pre_flush_out_valid", 64'(out_valid), 64'd1);
    doFlush(64'h400);
    checkOutput("post_flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("post_flush_hc", 64'(dut.hc_q), 64'd0);
    out_ready = 1'b1;
    applyStimulus(64'h4444_0005_0006_0007);
    waitDrain("flush_drain", 40);

    // Asynchronous reset mid-stream
    doFlush(64'h40);
    out_ready = 1'b0;
    applyStimulus(64'h0011_0022_0033_0044);
    repeat (3) step();
    #1 rst_n = 1'b0;
    expQ.delete();
    hwQ.delete();
    modelPc   = '0;
    modelDrop = 0;
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_out_inst", out_inst, 64'd0);
    checkOutput("async_rst_out_pc", out_pc, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);
    step();
    out_ready = 1'b1;
    applyStimulus(64'h0009_000A_000B_000C);
    waitDrain("post_rst_drain", 40);
    repeat (3) step();
    checkOutput("post_rst_no_stale", 64'(out_valid), 64'd0);

    // Random valid/ready traffic against the model
    doFlush({$urandom, $urandom} & ~64'h1);
    modelCount = 0;
    cyc = 0;
    while (modelCount < 10000 && cyc < 80000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    checkOutput("random_budget", 64'(modelCount >= 10000), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain("random_drain", 300);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
